// File: rtl/dac_spi_pkg.sv
// Shared types and field positions for the DAC SPI responder.
// Frames are {cmd, addr, data}; cmd and addr form an 8-bit header.
package dac_spi_pkg;

    // Commands the responder executes on a well-formed frame
    typedef enum logic [3:0] {
        CMD_WRITE_IN     = 4'h0,
        CMD_UPDATE       = 4'h1,
        CMD_WRITE_UPDATE = 4'h3,
        CMD_RESET        = 4'hF
    } dac_cmd_e;

    // Receiver FSM states
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } rx_state_e;

    // Bit positions of the cmd and addr fields inside the 8-bit frame header
    localparam int HEADER_BITS = 8;
    localparam int CMD_MSB     = 7;
    localparam int ADDR_MSB    = 3;

endpackage

// File: rtl/dac_spi_receiver_sync.sv
// Single-bit synchronizer with an edge-detect stage.
// All flops reset to 0, so a pin that is high at reset release produces
// a rise (never a fall) and an active-low select reads as "busy" until
// its synchronized level has actually been seen high.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain followed by one flop holding the previous level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// SPI DAC responder: oversamples cs_n/ldac_n/din/sclk on the system clock,
// deserializes {cmd, addr, data} frames MSB first and models the DAC input
// and output code registers.
module dac_spi_receiver
    import dac_spi_pkg::*;
#(
    parameter int FRAME_BITS  = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dac_cs_n,
    input  logic                  dac_ldac_n,
    input  logic                  dac_din,
    input  logic                  dac_sclk,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic [3:0]            frame_cmd,
    output logic [3:0]            frame_addr,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic [DATA_WIDTH-1:0] input_code,
    output logic [DATA_WIDTH-1:0] dac_code,
    output logic                  dac_update
);

    // Counter holds up to FRAME_BITS+1 so over-long frames stay distinguishable
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic din_sync, din_rise_unused, din_fall_unused;
    logic ldac_fall, ldac_level_unused, ldac_rise_unused;

    rx_state_e state, state_next;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;

    logic [HEADER_BITS-1:0] header;
    logic [3:0]             cmd_field;
    logic [3:0]             addr_field;
    logic [DATA_WIDTH-1:0]  data_field;

    logic                  clear_frame;
    logic                  shift_en;
    logic                  latch_fields;
    logic                  frame_valid_next;
    logic                  frame_error_next;
    logic                  dac_update_next;
    logic [DATA_WIDTH-1:0] input_code_next;
    logic [DATA_WIDTH-1:0] dac_code_next;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .d     (dac_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .d     (dac_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .clk   (clk),
        .rst   (rst),
        .d     (dac_din),
        .level (din_sync),
        .rise  (din_rise_unused),
        .fall  (din_fall_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ldac (
        .clk   (clk),
        .rst   (rst),
        .d     (dac_ldac_n),
        .level (ldac_level_unused),
        .rise  (ldac_rise_unused),
        .fall  (ldac_fall)
    );

    assign header     = shift_reg[FRAME_BITS-1 -: HEADER_BITS];
    assign cmd_field  = header[CMD_MSB -: 4];
    assign addr_field = header[ADDR_MSB -: 4];
    assign data_field = shift_reg[DATA_WIDTH-1:0];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, frame control and next values of the code registers
    always_comb begin
        state_next       = state;
        clear_frame      = 1'b0;
        shift_en         = 1'b0;
        latch_fields     = 1'b0;
        frame_valid_next = 1'b0;
        frame_error_next = 1'b0;
        dac_update_next  = 1'b0;
        input_code_next  = input_code;
        dac_code_next    = dac_code;

        case (state)
            WAIT_IDLE: begin
                if (cs_level) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    clear_frame = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = COMMIT;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            COMMIT: begin
                state_next = IDLE;
                if (bit_cnt == CNT_FULL) begin
                    latch_fields     = 1'b1;
                    frame_valid_next = 1'b1;
                    case (cmd_field)
                        CMD_WRITE_IN: begin
                            input_code_next = data_field;
                        end
                        CMD_UPDATE: begin
                            dac_code_next   = input_code;
                            dac_update_next = 1'b1;
                        end
                        CMD_WRITE_UPDATE: begin
                            input_code_next = data_field;
                            dac_code_next   = data_field;
                            dac_update_next = 1'b1;
                        end
                        CMD_RESET: begin
                            input_code_next = '0;
                            dac_code_next   = '0;
                            dac_update_next = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    frame_error_next = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_IDLE;
            end
        endcase

        // LDAC copies the input register as it will be after this cycle, so
        // same-cycle writes are forwarded and a reset command still yields 0
        if (ldac_fall && (state != WAIT_IDLE)) begin
            dac_code_next   = input_code_next;
            dac_update_next = 1'b1;
        end
    end

    // Shift register and saturating bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear_frame) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], din_sync};
            if (bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
        end
    end

    // Registered outputs: pulses, last valid frame fields and DAC codes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            dac_update  <= 1'b0;
            frame_cmd   <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
            input_code  <= '0;
            dac_code    <= '0;
        end else begin
            frame_valid <= frame_valid_next;
            frame_error <= frame_error_next;
            dac_update  <= dac_update_next;
            input_code  <= input_code_next;
            dac_code    <= dac_code_next;
            if (latch_fields) begin
                frame_cmd  <= cmd_field;
                frame_addr <= addr_field;
                frame_data <= data_field;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed bench for dac_spi_receiver: SCLK = clk/8, frames driven MSB first.
module tb_dac_spi_receiver;

    logic        clk;
    logic        rst;
    logic        dac_cs_n;
    logic        dac_ldac_n;
    logic        dac_din;
    logic        dac_sclk;
    logic        frame_valid;
    logic        frame_error;
    logic [3:0]  frame_cmd;
    logic [3:0]  frame_addr;
    logic [15:0] frame_data;
    logic [15:0] input_code;
    logic [15:0] dac_code;
    logic        dac_update;

    int compared;
    int mismatched;
    int valid_cnt;
    int error_cnt;
    int update_cnt;
    int valid_base;
    int error_base;
    int update_base;
    int latency;

    dac_spi_receiver #(
        .FRAME_BITS  (24),
        .DATA_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dac_cs_n    (dac_cs_n),
        .dac_ldac_n  (dac_ldac_n),
        .dac_din     (dac_din),
        .dac_sclk    (dac_sclk),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .frame_cmd   (frame_cmd),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .input_code  (input_code),
        .dac_code    (dac_code),
        .dac_update  (dac_update)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled on the falling edge, away from the active edge
    initial begin
        valid_cnt  = 0;
        error_cnt  = 0;
        update_cnt = 0;
        forever begin
            @(negedge clk);
            if (frame_valid) valid_cnt++;
            if (frame_error) error_cnt++;
            if (dac_update)  update_cnt++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snapshot_counts();
        valid_base  = valid_cnt;
        error_base  = error_cnt;
        update_base = update_cnt;
    endtask

    // Drive the low n bits of 'bits' MSB first; din changes while sclk is low
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            dac_din = bits[i];
            wait_clks(4);
            dac_sclk = 1'b1;
            wait_clks(4);
            dac_sclk = 1'b0;
        end
    endtask

    // One complete frame; optionally drops ldac_n ldac_delay clocks after
    // cs_n rises. Returns clocks from cs_n rising to the valid/error pulse.
    task automatic apply_stimulus(input logic [31:0] bits, input int n,
                                  input int ldac_delay, output int lat);
        dac_cs_n = 1'b0;
        wait_clks(4);
        send_bits(bits, n);
        wait_clks(4);
        dac_cs_n = 1'b1;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if ((frame_valid || frame_error) && lat < 0) lat = c;
            if (c == ldac_delay) begin
                @(negedge clk);
                dac_ldac_n = 1'b0;
            end
        end
        dac_ldac_n = 1'b1;
        wait_clks(4);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        dac_cs_n   = 1'b1;
        dac_ldac_n = 1'b1;
        dac_din    = 1'b0;
        dac_sclk   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_flags", {frame_valid, frame_error, dac_update, frame_cmd, frame_addr}, 32'h0);
        check_output("reset_frame_data", frame_data, 32'h0);
        check_output("reset_codes", {input_code, dac_code}, 32'h0);
        wait_clks(1);
        rst = 1'b0;
        wait_clks(10);

        // cmd 0x3 write and update, data 0xABCD
        $display("[TB] write+update frame 0xABCD");
        snapshot_counts();
        apply_stimulus(32'h30ABCD, 24, -1, latency);
        check_output("wu_latency", latency, 32'd4);
        check_output("wu_valid_cnt", valid_cnt - valid_base, 32'd1);
        check_output("wu_error_cnt", error_cnt - error_base, 32'd0);
        check_output("wu_update_cnt", update_cnt - update_base, 32'd1);
        check_output("wu_frame_fields", {frame_cmd, frame_addr, frame_data}, 32'h30ABCD);
        check_output("wu_input_code", input_code, 32'hABCD);
        check_output("wu_dac_code", dac_code, 32'hABCD);

        // cmd 0x0 write input only, then LDAC
        $display("[TB] write-input frame 0x1234 then LDAC");
        snapshot_counts();
        apply_stimulus(32'h011234, 24, -1, latency);
        check_output("wi_input_code", input_code, 32'h1234);
        check_output("wi_dac_hold", dac_code, 32'hABCD);
        check_output("wi_update_cnt", update_cnt - update_base, 32'd0);
        check_output("wi_frame_addr", frame_addr, 32'h1);
        dac_ldac_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("ldac_cycle1", {dac_update, dac_code}, {16'h0, 16'hABCD});
        @(posedge clk);
        #1;
        check_output("ldac_cycle2", {dac_update, dac_code}, {16'h0, 16'hABCD});
        @(posedge clk);
        #1;
        check_output("ldac_cycle3", {dac_update, dac_code}, {16'h1, 16'h1234});
        wait_clks(4);
        dac_ldac_n = 1'b1;
        wait_clks(6);
        check_output("ldac_update_cnt", update_cnt - update_base, 32'd1);

        // Short and long frames are rejected
        $display("[TB] 23-bit and 25-bit frames");
        snapshot_counts();
        apply_stimulus(32'h005555 >> 1, 23, -1, latency);
        check_output("short_latency", latency, 32'd4);
        apply_stimulus(32'h005555, 25, -1, latency);
        check_output("bad_error_cnt", error_cnt - error_base, 32'd2);
        check_output("bad_valid_cnt", valid_cnt - valid_base, 32'd0);
        check_output("bad_update_cnt", update_cnt - update_base, 32'd0);
        check_output("bad_codes", {input_code, dac_code}, {16'h1234, 16'h1234});
        check_output("bad_frame_data", frame_data, 32'h1234);

        // LDAC in the commit cycle of a write-input frame
        $display("[TB] commit coincident with LDAC");
        snapshot_counts();
        apply_stimulus(32'h000F0F, 24, 1, latency);
        check_output("fwd_codes", {input_code, dac_code}, {16'h0F0F, 16'h0F0F});
        check_output("fwd_update_cnt", update_cnt - update_base, 32'd1);
        check_output("fwd_valid_cnt", valid_cnt - valid_base, 32'd1);

        // Reset in the middle of a frame
        $display("[TB] reset after 10 bits");
        dac_cs_n = 1'b0;
        wait_clks(4);
        send_bits(32'h305A5A >> 14, 10);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        snapshot_counts();
        send_bits(32'h305A5A, 14);
        wait_clks(4);
        dac_cs_n = 1'b1;
        wait_clks(12);
        check_output("rst_valid_cnt", valid_cnt - valid_base, 32'd0);
        check_output("rst_error_cnt", error_cnt - error_base, 32'd0);
        check_output("rst_codes", {input_code, dac_code}, 32'h0);
        apply_stimulus(32'h3000FF, 24, -1, latency);
        check_output("rst_clean_dac", dac_code, 32'h00FF);
        check_output("rst_clean_valid", valid_cnt - valid_base, 32'd1);

        // Unrecognised command: frame accepted, registers untouched
        $display("[TB] unknown command 0x7");
        snapshot_counts();
        apply_stimulus(32'h72BEEF, 24, -1, latency);
        check_output("unk_valid_cnt", valid_cnt - valid_base, 32'd1);
        check_output("unk_update_cnt", update_cnt - update_base, 32'd0);
        check_output("unk_fields", {frame_cmd, frame_addr, frame_data}, 32'h72BEEF);
        check_output("unk_codes", {input_code, dac_code}, {16'h00FF, 16'h00FF});

        // Reset command after a full-scale code
        $display("[TB] reset command");
        apply_stimulus(32'h30FFFF, 24, -1, latency);
        check_output("full_scale_dac", dac_code, 32'hFFFF);
        snapshot_counts();
        apply_stimulus(32'hF00000, 24, -1, latency);
        check_output("rcmd_codes", {input_code, dac_code}, 32'h0);
        check_output("rcmd_update_cnt", update_cnt - update_base, 32'd1);
        check_output("rcmd_frame_cmd", frame_cmd, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dac_spi_receiver.md
Name: dac_spi_receiver

Overview:
- Synthesizable SPI-DAC responder: the receiving end of the DAC serial link driven by the ASIC function interface (cs_n/ldac_n/din/sclk).
- Oversamples the four SPI pins on the system clock, deserializes 24-bit frames and maintains DAC input and output code registers.
- Used as an on-chip loopback/DAC model so the SoC can check DAC frames without external hardware.

Parameters:
- FRAME_BITS, 24, bits per valid frame: cmd[23:20], addr[19:16], data[15:0], MSB first.
- DATA_WIDTH, 16, DAC code width; FRAME_BITS = 8 + DATA_WIDTH is required.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each SPI input (min 2).

Ports:
- clk  in  1  system clock (S_AXI_ACLK domain); must be ≥ 4x SCLK rate.
- rst  in  1  asynchronous, active-high reset.
- dac_cs_n  in  1  SPI chip select, active low.
- dac_ldac_n  in  1  load-DAC strobe, active low; the falling edge acts.
- dac_din  in  1  serial data, sampled on SCLK rising edge.
- dac_sclk  in  1  serial clock.
- frame_valid  out  1  one-cycle pulse: a well-formed frame was committed.
- frame_error  out  1  one-cycle pulse: the frame ended with bit count ≠ FRAME_BITS.
- frame_cmd  out  4  cmd field of the last valid frame.
- frame_addr  out  4  addr field of the last valid frame.
- frame_data  out  DATA_WIDTH  data field of the last valid frame.
- input_code  out  DATA_WIDTH  DAC input register.
- dac_code  out  DATA_WIDTH  DAC output register (the modelled analog code).
- dac_update  out  1  one-cycle pulse whenever dac_code is loaded.

Behaviour:
- Reset values: all outputs 0; shift register and bit counter 0; FSM in WAIT_IDLE.
- Synchronization:
  - Each input passes through SYNC_STAGES flops plus one edge-detect flop.
  - Edges (sclk_rise, cs_fall, cs_rise, ldac_fall) are single-cycle strobes of the synchronized signals.
- FSM:
  - WAIT_IDLE: entered on reset. Moves to IDLE once synced cs_n is 1. A frame already in progress at reset release is ignored.
  - IDLE: on cs_fall, clear bit_cnt and the shift register, then go to SHIFT.
  - SHIFT: on sclk_rise, shift = {shift[FRAME_BITS-2:0], din_sync}.
    - bit_cnt increments, saturating at FRAME_BITS+1; extra bits still shift, so the register holds the last 24 bits.
    - On cs_rise, go to COMMIT.
  - COMMIT (1 cycle), then IDLE:
    - If bit_cnt == FRAME_BITS: latch cmd/addr/data, pulse frame_valid, execute the command.
    - Otherwise: pulse frame_error; frame_* fields, input_code and dac_code are unchanged.
- Commands (valid frames only; addr is recorded but not decoded):
  - 0x0: input_code <= data.
  - 0x1: dac_code <= input_code; pulse dac_update.
  - 0x3: input_code <= data and dac_code <= data; pulse dac_update.
  - 0xF: input_code <= 0, dac_code <= 0; pulse dac_update.
  - Any other value: frame_valid still pulses; no register change.
- LDAC:
  - ldac_fall in any state except WAIT_IDLE: dac_code <= input_code; pulse dac_update.
  - LDAC in the same cycle as a COMMIT with cmd 0x0 or 0x3: dac_code takes the newly written data (forwarded).
  - LDAC in the same cycle as cmd 0xF: the reset result (0) wins.
  - Only one dac_update pulse is issued per cycle.
- An SCLK edge coincident with cs_rise in the same cycle is not counted.
- Latency: pin cs_n rising edge → frame_valid = SYNC_STAGES+2 clk cycles. Pin ldac_n falling edge → dac_update = SYNC_STAGES+1 cycles.
- Reset asserted mid-frame: all state clears immediately; behaviour continues as from reset (WAIT_IDLE).

Decomposition:
- Package dac_spi_pkg holds:
  - Enum dac_cmd_e: CMD_WRITE_IN=4'h0, CMD_UPDATE=4'h1, CMD_WRITE_UPDATE=4'h3, CMD_RESET=4'hF.
  - FSM state enum: WAIT_IDLE, IDLE, SHIFT, COMMIT.
  - Localparams CMD_MSB, ADDR_MSB.
- One sub-module, sync_edge_detect (parameter SYNC_STAGES): synchronizes one bit and outputs level, rise and fall. Instantiated 4x.

Test Plan:
- Frame cmd 0x3, addr 0x0, data 0xABCD (24 SCLKs, SCLK = clk/8) → one frame_valid; frame_data=0xABCD; input_code=dac_code=0xABCD; one dac_update.
- Frame cmd 0x0, data 0x1234, then ldac_n low pulse → input_code=0x1234 after the frame; dac_code updates to 0x1234 only SYNC_STAGES+1 cycles after LDAC falls.
- 23-bit frame, then a 25-bit frame, both carrying data 0x5555 → two frame_error pulses, no frame_valid; input_code and dac_code unchanged.
- Commit of cmd 0x0 data 0x0F0F on the same clk as ldac_fall → dac_code=0x0F0F; exactly one dac_update.
- rst pulsed after 10 of 24 bits while cs_n stays low, remaining bits clocked, then a clean 0x3/0x00FF frame → first frame ignored (no valid/error); second frame yields dac_code=0x00FF.
- Frame cmd 0xF after dac_code=0xFFFF → input_code=dac_code=0; dac_update pulses.
